muldiv_sequencer: RTL and testbench

//   Iterative multiply/divide unit with its sequencer and the HI/LO registers for the

---
 rtl/muldiv_sequencer.sv | 178 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS pipeline.
// Each MUL/DIV step takes one clock. A final FIX cycle applies the sign
// correction and commits the result to HI/LO.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hilo_read,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             muldiv_stall
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e               state_q, state_d;
  // Upper half: product high / remainder. Lower half: multiplier / dividend->quotient.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Holds the multiplicand or the divisor magnitude.
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 zdiv_q, zdiv_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  // Datapath terms used by the next-state logic.
  logic                 is_signed;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod_neg;
  logic [WIDTH-1:0]     quo, rem;

  // State registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      zdiv_q   <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      zdiv_q   <= zdiv_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Next-state, iteration datapath and HI/LO commit.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    zdiv_d   = zdiv_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = (state_q == StFix);

    is_signed = ~op[0];
    a_neg     = is_signed & rs_data[WIDTH-1];
    b_neg     = is_signed & rt_data[WIDTH-1];
    a_mag     = a_neg ? (~rs_data + 1'b1) : rs_data;
    b_mag     = b_neg ? (~rt_data + 1'b1) : rt_data;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod_neg  = ~acc_q + 1'b1;
    quo       = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sa_d     = a_neg;
          sb_d     = b_neg;
          cnt_d    = '0;
          is_div_d = op[1];
          zdiv_d   = 1'b0;
          if (op[1]) begin
            opb_d = b_mag;
            if (rt_data == '0) begin
              // Park the dividend magnitude as the remainder; FIX restores its sign.
              zdiv_d  = 1'b1;
              acc_d   = {a_mag, {WIDTH{1'b0}}};
              state_d = StFix;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, a_mag};
              state_d = StDiv;
            end
          end else begin
            opb_d   = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            state_d = StMul;
          end
        end else begin
          if (hi_we) hi_d = rs_data;
          if (lo_we) lo_d = rs_data;
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StDiv: begin
        // Restoring step: keep the difference only when it did not go negative.
        if (!div_diff[WIDTH]) begin
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = sa_q ? (~rem + 1'b1) : rem;
          if (zdiv_q) begin
            lo_d = {WIDTH{1'b1}};
          end else begin
            lo_d = (sa_q ^ sb_q) ? (~quo + 1'b1) : quo;
          end
        end else begin
          hi_d = (sa_q ^ sb_q) ? prod_neg[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d = (sa_q ^ sb_q) ? prod_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; the stall is combinational toward the hazard unit.
  always_comb begin
    hi           = hi_q;
    lo           = lo_q;
    busy         = (state_q != StIdle);
    done         = done_q;
    muldiv_stall = busy & (hilo_read | start | hi_we | lo_we);
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against a plain-arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        hilo_read, hi_we, lo_we;
  logic [31:0] hi, lo;
  logic        busy, done, muldiv_stall;

  int tests_run = 0;
  int fails     = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .hilo_read    (hilo_read),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done),
    .muldiv_stall (muldiv_stall)
  );

  always #5 clk = ~clk;

  // Reference result from 64-bit integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'b00: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
      2'b01: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
      2'b10: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin sq = sa / sb; sr = sa % sb; eh = sr[31:0]; el = sq[31:0]; end
      end
      default: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin uq = ua / ub; ur = ua % ub; eh = ur[31:0]; el = uq[31:0]; end
      end
    endcase
  endfunction

  // Launch one operation and wait (bounded) for it to finish.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mt, output int bc, output logic d_end, output logic d_next);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b; hi_we = mt; lo_we = mt;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    d_end = done;
    @(negedge clk);
    d_next = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hilo_read = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if ({hi, lo} !== 64'h0) begin
      fails++; $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo);
    end
    tests_run++;
    if ({busy, done, muldiv_stall} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got busy/done/stall=%b want 000",
                        {busy, done, muldiv_stall});
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [5] = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b10};
    logic [31:0] as  [5] = '{32'hFFFF_FFFE, 32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'd3, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] wh  [5] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'd0};
    logic [31:0] wl  [5] = '{32'hFFFF_FFFA, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int          wb  [5] = '{33, 33, 33, 1, 33};
    int bc; logic de, dn;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, bc, de, dn);
      tests_run++;
      if (bc != wb[i]) begin
        fails++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, wb[i]);
      end
      tests_run++;
      if ({de, dn} !== 2'b10) begin
        fails++; $display("FAIL dir%0d_done_pulse: got %b want 10", i, {de, dn});
      end
      tests_run++;
      if (hi !== wh[i] || lo !== wl[i]) begin
        fails++; $display("FAIL dir%0d_result: got hi=%h lo=%h want hi=%h lo=%h",
                          i, hi, lo, wh[i], wl[i]);
      end
    end
  endtask

  task automatic test_stall();
    int bc = 0, sc = 0;
    logic de;
    @(negedge clk);
    hilo_read = 1'b1; start = 1'b1; op = 2'b01;
    rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      if (muldiv_stall === 1'b1) sc++;
      // A re-presented start and MTHI mid-operation must be ignored.
      if (bc == 5) begin
        start = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd4; hi_we = 1'b1;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
    end
    de = done;
    tests_run++;
    if (bc != 33 || sc != 33) begin
      fails++; $display("FAIL stall_cycles: got busy=%0d stall=%0d want 33/33", bc, sc);
    end
    tests_run++;
    if (muldiv_stall !== 1'b0 || de !== 1'b1) begin
      fails++; $display("FAIL stall_release: got stall=%b done=%b want 0/1", muldiv_stall, de);
    end
    tests_run++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
      fails++; $display("FAIL stall_result: got hi=%h lo=%h want fffffffe/00000001", hi, lo);
    end
    hilo_read = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL stall_no_relaunch: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int bc; logic de, dn;
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs_data = 32'd1000; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      fails++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                        busy, done, hi, lo);
    end
    run_op(2'b00, 32'd6, 32'd7, 1'b0, bc, de, dn);
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd42 || bc != 33) begin
      fails++; $display("FAIL after_reset_mult: got hi=%h lo=%h busy=%0d want 0/42/33",
                        hi, lo, bc);
    end
  endtask

  task automatic test_mt();
    int bc; logic de, dn;
    int sc = 0;
    @(negedge clk);
    hi_we = 1'b1; rs_data = 32'h1234; hilo_read = 1'b1;
    if (muldiv_stall === 1'b1) sc++;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; rs_data = 32'h5678;
    if (muldiv_stall === 1'b1) sc++;
    @(negedge clk);
    lo_we = 1'b0; hilo_read = 1'b0;
    if (muldiv_stall === 1'b1) sc++;
    tests_run++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      fails++; $display("FAIL mt_write: got hi=%h lo=%h want 00001234/00005678", hi, lo);
    end
    tests_run++;
    if (sc != 0) begin
      fails++; $display("FAIL mt_stall: got %0d stall cycles want 0", sc);
    end
    // Start together with MTHI/MTLO: the operation wins.
    run_op(2'b01, 32'd7, 32'd9, 1'b1, bc, de, dn);
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd63) begin
      fails++; $display("FAIL start_beats_mt: got hi=%h lo=%h want 0/63", hi, lo);
    end
  endtask

  task automatic test_random();
    int bc, wb; logic de, dn;
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      model(o, a, b, eh, el);
      wb = (o[1] && b == 0) ? 1 : 33;
      run_op(o, a, b, 1'b0, bc, de, dn);
      tests_run++;
      if (hi !== eh || lo !== el || bc != wb || {de, dn} !== 2'b10) begin
        fails++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: got hi=%h lo=%h busy=%0d done=%b want hi=%h lo=%h busy=%0d done=10",
                 i, o, a, b, hi, lo, bc, {de, dn}, eh, el, wb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_mt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
